// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the control-word pipeline.
package ctrl_pipe_pkg;

  // Hazard-unit state: RUN passes instructions, STALL holds IF/ID and inserts bubbles.
  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Control-word bit map produced by the control unit.
  localparam int REGWRITE = 0;
  localparam int MEMWRITE = 1;
  localparam int MEMTOREG = 2;
  localparam int ALUSRC   = 3;
  localparam int ALUOP_LO = 4;
  localparam int ALUOP_HI = 5;
  localparam int SBIT     = 6;
  localparam int PCSRC    = 7;

  // A bubble carries the all-zero control word: no writes, no memory access.
  localparam int CTRL_NOP = 0;

  // Width of the remaining-bubble counter; covers stall lengths up to 7.
  localparam int STALL_CW = 3;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline register holding {control word, destination register, valid}.
// i_load_zero replaces the incoming instruction with a NOP bubble.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load_zero,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [RD_W-1:0]   i_rd,
  input  logic              i_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [RD_W-1:0]   o_rd,
  output logic              o_valid
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [RD_W-1:0]   r_rd;
  logic              r_valid;

  // Capture the upstream instruction every edge, or a bubble when asked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl  <= CTRL_W'(CTRL_NOP);
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else if (i_load_zero) begin
      r_ctrl  <= CTRL_W'(CTRL_NOP);
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_ctrl  <= i_ctrl;
      r_rd    <= i_rd;
      r_valid <= i_valid;
    end
  end

  assign o_ctrl  = r_ctrl;
  assign o_rd    = r_rd;
  assign o_valid = r_valid;

endmodule

// File: rtl/ctrl_pipeline_chain.sv
// Control-word pipeline from ID through NUM_STAGES registers, with load-use
// stall, branch flush, bubble insertion and saturating stall/flush statistics.
// Stage 0 is EX; its fields sit in the LSBs of the flattened stage outputs.
module ctrl_pipeline_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int CTRL_W     = 8,
  parameter int RD_W       = 4,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CTRL_W-1:0]            ctrl_in,
  input  logic                         valid_in,
  input  logic [RD_W-1:0]              rd_in,
  input  logic [RD_W-1:0]              rn_in,
  input  logic [RD_W-1:0]              rm_in,
  input  logic                         uses_rn,
  input  logic                         uses_rm,
  input  logic                         branch_taken,
  output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [NUM_STAGES*RD_W-1:0]   stage_rd,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic                         pc_enable,
  output logic                         if_id_enable,
  output logic                         if_id_flush,
  output logic                         bubble_sel,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt,
  output state_t                       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                r_state;
  logic [STALL_CW-1:0]   r_stall_left;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  logic [CTRL_W-1:0]     w_ctrl0;
  logic [RD_W-1:0]       w_rd0;
  logic                  w_valid0;
  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_bubble;

  // Stage 0 loads from ID (or a bubble); later stages shift unconditionally.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      ctrl_stage_reg #(.CTRL_W(CTRL_W), .RD_W(RD_W)) u_reg (
        .clk         (clk),
        .reset       (reset),
        .i_load_zero (w_bubble),
        .i_ctrl      (ctrl_in),
        .i_rd        (rd_in),
        .i_valid     (valid_in),
        .o_ctrl      (stage_ctrl[CTRL_W-1:0]),
        .o_rd        (stage_rd[RD_W-1:0]),
        .o_valid     (stage_valid[0])
      );
    end else begin : g_next
      ctrl_stage_reg #(.CTRL_W(CTRL_W), .RD_W(RD_W)) u_reg (
        .clk         (clk),
        .reset       (reset),
        .i_load_zero (1'b0),
        .i_ctrl      (stage_ctrl[(k-1)*CTRL_W +: CTRL_W]),
        .i_rd        (stage_rd[(k-1)*RD_W +: RD_W]),
        .i_valid     (stage_valid[k-1]),
        .o_ctrl      (stage_ctrl[k*CTRL_W +: CTRL_W]),
        .o_rd        (stage_rd[k*RD_W +: RD_W]),
        .o_valid     (stage_valid[k])
      );
    end
  end

  assign w_ctrl0  = stage_ctrl[CTRL_W-1:0];
  assign w_rd0    = stage_rd[RD_W-1:0];
  assign w_valid0 = stage_valid[0];

  // Load-use: a load writing a register in EX that the ID instruction reads.
  assign w_hazard = w_valid0 && w_ctrl0[MEMTOREG] && w_ctrl0[REGWRITE] && valid_in &&
                    ((uses_rn && (rn_in == w_rd0)) || (uses_rm && (rm_in == w_rd0)));

  // The hazard cycle itself is the first stall cycle; STALL covers the rest.
  // A taken branch always wins so the branch target can load.
  assign w_stall  = !branch_taken &&
                    ((r_state == STALL) || ((r_state == RUN) && w_hazard));
  assign w_bubble = w_stall || branch_taken;

  assign pc_enable    = !w_stall;
  assign if_id_enable = !w_stall;
  assign if_id_flush  = branch_taken;
  assign bubble_sel   = w_bubble;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;
  assign dbg_state    = r_state;

  // Hazard FSM; r_stall_left counts stall cycles still owed while in STALL.
  // With a one-bubble stall the hazard cycle is enough, so RUN is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_stall_left <= '0;
    end else if (branch_taken) begin
      r_state      <= RUN;
      r_stall_left <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard && (LOAD_STALL > 1)) begin
            r_state      <= STALL;
            r_stall_left <= STALL_CW'(LOAD_STALL - 1);
          end
        end
        STALL: begin
          r_stall_left <= r_stall_left - STALL_CW'(1);
          if (r_stall_left == STALL_CW'(1)) r_state <= RUN;
        end
        default: begin
          r_state      <= RUN;
          r_stall_left <= '0;
        end
      endcase
    end
  end

  // Saturating statistics: stall cycles (PC frozen) and flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (branch_taken && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline_chain.sv
// Bench for ctrl_pipeline_chain: two instances share the ID-side inputs,
// A with a 1-bubble stall and 16-bit counters, B with a 3-bubble stall and
// 4-bit counters. Directed scenarios use hand-derived values; the random run
// is compared against a small behavioural model of both instances.
module tb_ctrl_pipeline_chain;
  import ctrl_pipe_pkg::*;

  localparam int NS = 3;
  localparam int CW = 8;
  localparam int RW = 4;
  localparam logic [CW-1:0] C_ADD  = CW'((1 << REGWRITE) | (1 << ALUSRC));                    // 0x09
  localparam logic [CW-1:0] C_LDRB = CW'((1 << REGWRITE) | (1 << MEMTOREG) | (1 << ALUSRC));  // 0x0D

  // ---------------- clock / reset / inputs ----------------
  logic clk = 1'b0;
  logic reset;
  logic [CW-1:0] ctrl_in;
  logic valid_in;
  logic [RW-1:0] rd_in, rn_in, rm_in;
  logic uses_rn, uses_rm, branch_taken;

  always #5 clk = ~clk;

  logic [NS*CW-1:0] a_stage_ctrl, b_stage_ctrl;
  logic [NS*RW-1:0] a_stage_rd, b_stage_rd;
  logic [NS-1:0]    a_stage_valid, b_stage_valid;
  logic a_pc_enable, a_if_id_enable, a_if_id_flush, a_bubble_sel;
  logic b_pc_enable, b_if_id_enable, b_if_id_flush, b_bubble_sel;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic [3:0]  b_stall_cnt, b_flush_cnt;
  state_t a_dbg_state, b_dbg_state;

  ctrl_pipeline_chain #(.NUM_STAGES(NS), .CTRL_W(CW), .RD_W(RW), .LOAD_STALL(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in), .rd_in(rd_in),
    .rn_in(rn_in), .rm_in(rm_in), .uses_rn(uses_rn), .uses_rm(uses_rm), .branch_taken(branch_taken),
    .stage_ctrl(a_stage_ctrl), .stage_rd(a_stage_rd), .stage_valid(a_stage_valid),
    .pc_enable(a_pc_enable), .if_id_enable(a_if_id_enable), .if_id_flush(a_if_id_flush),
    .bubble_sel(a_bubble_sel), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .dbg_state(a_dbg_state)
  );

  ctrl_pipeline_chain #(.NUM_STAGES(NS), .CTRL_W(CW), .RD_W(RW), .LOAD_STALL(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in), .rd_in(rd_in),
    .rn_in(rn_in), .rm_in(rm_in), .uses_rn(uses_rn), .uses_rm(uses_rm), .branch_taken(branch_taken),
    .stage_ctrl(b_stage_ctrl), .stage_rd(b_stage_rd), .stage_valid(b_stage_valid),
    .pc_enable(b_pc_enable), .if_id_enable(b_if_id_enable), .if_id_flush(b_if_id_flush),
    .bubble_sel(b_bubble_sel), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .dbg_state(b_dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // Each instance: an array of in-flight instructions, a count of stall
  // cycles still owed, and two saturating statistics.
  logic [CW-1:0] m_ctrl  [2][NS];
  logic [RW-1:0] m_rd    [2][NS];
  logic          m_valid [2][NS];
  int m_left[2], m_stall[2], m_flush[2], m_ls[2], m_max[2];

  task automatic model_reset();
    m_ls[0] = 1;  m_max[0] = 65535;
    m_ls[1] = 3;  m_max[1] = 15;
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      for (int k = 0; k < NS; k++) begin
        m_ctrl[i][k] = '0; m_rd[i][k] = '0; m_valid[i][k] = 1'b0;
      end
    end
  endtask

  function automatic logic m_hazard(int i);
    logic is_load, reads;
    is_load = m_valid[i][0] && m_ctrl[i][0][MEMTOREG] && m_ctrl[i][0][REGWRITE];
    reads   = (uses_rn && rn_in == m_rd[i][0]) || (uses_rm && rm_in == m_rd[i][0]);
    return is_load && valid_in && reads;
  endfunction

  function automatic logic m_stalling(int i);
    return !branch_taken && (m_left[i] > 0 || m_hazard(i));
  endfunction

  function automatic logic [NS*CW-1:0] m_exp_ctrl(int i);
    logic [NS*CW-1:0] r;
    for (int k = 0; k < NS; k++) r[k*CW +: CW] = m_ctrl[i][k];
    return r;
  endfunction

  function automatic logic [NS*RW-1:0] m_exp_rd(int i);
    logic [NS*RW-1:0] r;
    for (int k = 0; k < NS; k++) r[k*RW +: RW] = m_rd[i][k];
    return r;
  endfunction

  function automatic logic [NS-1:0] m_exp_valid(int i);
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) r[k] = m_valid[i][k];
    return r;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic hz, st;
      hz = m_hazard(i);
      st = m_stalling(i);
      for (int k = NS - 1; k > 0; k--) begin
        m_ctrl[i][k] = m_ctrl[i][k-1]; m_rd[i][k] = m_rd[i][k-1]; m_valid[i][k] = m_valid[i][k-1];
      end
      if (st || branch_taken) begin
        m_ctrl[i][0] = '0; m_rd[i][0] = '0; m_valid[i][0] = 1'b0;
      end else begin
        m_ctrl[i][0] = ctrl_in; m_rd[i][0] = rd_in; m_valid[i][0] = valid_in;
      end
      if (branch_taken)       m_left[i] = 0;
      else if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
      else if (hz)            m_left[i] = m_ls[i] - 1;
      if (st && m_stall[i] < m_max[i]) m_stall[i]++;
      if (branch_taken && m_flush[i] < m_max[i]) m_flush[i]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    ctrl_in = '0; valid_in = 1'b0; rd_in = '0; rn_in = '0; rm_in = '0;
    uses_rn = 1'b0; uses_rm = 1'b0; branch_taken = 1'b0;
  endtask

  // Inputs change at posedge+1; outputs are sampled at posedge+3 or later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive_load_then_add();
    ctrl_in = C_LDRB; rd_in = 4'd2; valid_in = 1'b1;
    tick();
    ctrl_in = C_ADD; rd_in = 4'd3; rn_in = 4'd2; uses_rn = 1'b1; valid_in = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    settle();
    n_checks++; if (a_stage_valid !== 3'b000) $display("FAIL reset_valid: got %b want 000", a_stage_valid); else n_pass++;
    n_checks++; if (a_pc_enable !== 1'b1) $display("FAIL reset_pc_enable: got %b want 1", a_pc_enable); else n_pass++;
    n_checks++; if (a_if_id_enable !== 1'b1) $display("FAIL reset_if_id_enable: got %b want 1", a_if_id_enable); else n_pass++;
    n_checks++; if ({a_if_id_flush, a_bubble_sel} !== 2'b00) $display("FAIL reset_flush_bubble: got %b want 00", {a_if_id_flush, a_bubble_sel}); else n_pass++;
    n_checks++; if ({a_stall_cnt, a_flush_cnt} !== 32'd0) $display("FAIL reset_counters: got %h want 0", {a_stall_cnt, a_flush_cnt}); else n_pass++;
    n_checks++; if (b_dbg_state !== RUN) $display("FAIL reset_state: got %0d want RUN", b_dbg_state); else n_pass++;
  endtask

  task automatic test_latency();
    apply_reset();
    ctrl_in = C_ADD; rd_in = 4'd5; valid_in = 1'b1;
    tick();
    idle();
    n_checks++; if ({a_stage_ctrl[7:0], a_stage_rd[3:0], a_stage_valid} !== {C_ADD, 4'd5, 3'b001})
      $display("FAIL latency_stage0: got %h/%h/%b want 09/5/001", a_stage_ctrl[7:0], a_stage_rd[3:0], a_stage_valid); else n_pass++;
    tick();
    n_checks++; if ({a_stage_ctrl[15:8], a_stage_rd[7:4], a_stage_valid} !== {C_ADD, 4'd5, 3'b010})
      $display("FAIL latency_stage1: got %h/%h/%b want 09/5/010", a_stage_ctrl[15:8], a_stage_rd[7:4], a_stage_valid); else n_pass++;
    tick();
    n_checks++; if ({a_stage_ctrl[23:16], a_stage_rd[11:8], a_stage_valid} !== {C_ADD, 4'd5, 3'b100})
      $display("FAIL latency_stage2: got %h/%h/%b want 09/5/100", a_stage_ctrl[23:16], a_stage_rd[11:8], a_stage_valid); else n_pass++;
  endtask

  task automatic test_load_use();
    apply_reset();
    drive_load_then_add();
    settle();
    n_checks++; if ({a_pc_enable, a_if_id_enable, a_bubble_sel} !== 3'b001)
      $display("FAIL load_use_stall: got pc/ifid/bubble=%b want 001", {a_pc_enable, a_if_id_enable, a_bubble_sel}); else n_pass++;
    tick();
    settle();
    n_checks++; if ({a_pc_enable, a_bubble_sel, a_stage_valid[0]} !== 3'b100)
      $display("FAIL load_use_resume: got pc/bubble/v0=%b want 100", {a_pc_enable, a_bubble_sel, a_stage_valid[0]}); else n_pass++;
    tick();
    idle();
    n_checks++; if (a_stage_ctrl !== {C_LDRB, 8'h00, C_ADD}) $display("FAIL load_use_stages: got %h want 0d0009", a_stage_ctrl); else n_pass++;
    n_checks++; if (a_stage_valid !== 3'b101) $display("FAIL load_use_valid: got %b want 101", a_stage_valid); else n_pass++;
    n_checks++; if (a_stall_cnt !== 16'd1) $display("FAIL load_use_stall_cnt: got %0d want 1", a_stall_cnt); else n_pass++;
  endtask

  task automatic test_long_stall();
    int frozen = 0;
    apply_reset();
    drive_load_then_add();
    for (int j = 0; j < 5; j++) begin
      settle();
      if (!b_pc_enable) frozen++;
      tick();
      if (j == 2) begin
        n_checks++; if ({b_stage_ctrl, b_stage_valid} !== '0)
          $display("FAIL long_stall_bubbles: got %h/%b want 000000/000", b_stage_ctrl, b_stage_valid); else n_pass++;
      end
    end
    idle();
    n_checks++; if (frozen != 3) $display("FAIL long_stall_cycles: got %0d want 3", frozen); else n_pass++;
    n_checks++; if (b_stall_cnt !== 4'd3) $display("FAIL long_stall_cnt: got %0d want 3", b_stall_cnt); else n_pass++;
    n_checks++; if (b_stage_ctrl[15:8] !== C_ADD) $display("FAIL long_stall_add_late: got %h want 09", b_stage_ctrl[15:8]); else n_pass++;
  endtask

  task automatic test_flush_in_stall();
    apply_reset();
    drive_load_then_add();
    tick();
    branch_taken = 1'b1;
    settle();
    n_checks++; if ({b_if_id_flush, b_pc_enable, b_bubble_sel} !== 3'b111)
      $display("FAIL flush_in_stall_outputs: got flush/pc/bubble=%b want 111", {b_if_id_flush, b_pc_enable, b_bubble_sel}); else n_pass++;
    tick();
    branch_taken = 1'b0;
    settle();
    n_checks++; if (b_dbg_state !== RUN || b_pc_enable !== 1'b1)
      $display("FAIL flush_in_stall_run: got state=%0d pc=%b want 0/1", b_dbg_state, b_pc_enable); else n_pass++;
    n_checks++; if ({b_flush_cnt, b_stall_cnt} !== {4'd1, 4'd1})
      $display("FAIL flush_in_stall_counts: got flush=%0d stall=%0d want 1/1", b_flush_cnt, b_stall_cnt); else n_pass++;
    idle();
  endtask

  task automatic test_same_cycle();
    apply_reset();
    drive_load_then_add();
    branch_taken = 1'b1;
    settle();
    n_checks++; if ({a_pc_enable, a_if_id_flush, a_bubble_sel} !== 3'b111)
      $display("FAIL same_cycle_outputs: got pc/flush/bubble=%b want 111", {a_pc_enable, a_if_id_flush, a_bubble_sel}); else n_pass++;
    tick();
    idle();
    n_checks++; if ({a_stall_cnt, a_flush_cnt} !== {16'd0, 16'd1})
      $display("FAIL same_cycle_counts: got stall=%0d flush=%0d want 0/1", a_stall_cnt, a_flush_cnt); else n_pass++;
  endtask

  task automatic test_flush_saturate();
    apply_reset();
    branch_taken = 1'b1;
    repeat (20) tick();
    idle();
    n_checks++; if (b_flush_cnt !== 4'd15) $display("FAIL flush_saturate_b: got %0d want 15", b_flush_cnt); else n_pass++;
    n_checks++; if (a_flush_cnt !== 16'd20) $display("FAIL flush_count_a: got %0d want 20", a_flush_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    drive_load_then_add();
    tick();
    settle();
    n_checks++; if (b_dbg_state !== STALL || b_pc_enable !== 1'b0)
      $display("FAIL mid_stall_entry: got state=%0d pc=%b want 1/0", b_dbg_state, b_pc_enable); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if ({b_dbg_state, b_pc_enable, b_bubble_sel, b_stage_valid} !== {RUN, 1'b1, 1'b0, 3'b000})
      $display("FAIL mid_stall_async_reset: got state/pc/bubble/valid=%b want 0100000", {b_dbg_state, b_pc_enable, b_bubble_sel, b_stage_valid}); else n_pass++;
    n_checks++; if (b_stall_cnt !== 4'd0) $display("FAIL mid_stall_cnt_cleared: got %0d want 0", b_stall_cnt); else n_pass++;
    apply_reset();
  endtask

  task automatic test_random();
    logic [NS*CW-1:0] act_ctrl;
    logic [NS*RW-1:0] act_rd;
    logic [NS-1:0]    act_valid;
    logic [3:0]       act_ctl, exp_ctl;
    logic [15:0]      act_sc, act_fc;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: ctrl_in = C_LDRB;
        1: ctrl_in = C_ADD;
        2: ctrl_in = '0;
        default: ctrl_in = CW'($urandom);
      endcase
      valid_in     = ($urandom_range(0, 3) != 0);
      rd_in        = RW'($urandom_range(0, 3));
      rn_in        = RW'($urandom_range(0, 3));
      rm_in        = RW'($urandom_range(0, 3));
      uses_rn      = 1'($urandom_range(0, 1));
      uses_rm      = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 9) == 0);
      settle();
      for (int i = 0; i < 2; i++) begin
        act_ctrl  = (i == 0) ? a_stage_ctrl  : b_stage_ctrl;
        act_rd    = (i == 0) ? a_stage_rd    : b_stage_rd;
        act_valid = (i == 0) ? a_stage_valid : b_stage_valid;
        act_ctl   = (i == 0) ? {a_pc_enable, a_if_id_enable, a_if_id_flush, a_bubble_sel}
                             : {b_pc_enable, b_if_id_enable, b_if_id_flush, b_bubble_sel};
        act_sc    = (i == 0) ? a_stall_cnt : {12'd0, b_stall_cnt};
        act_fc    = (i == 0) ? a_flush_cnt : {12'd0, b_flush_cnt};
        exp_ctl   = {!m_stalling(i), !m_stalling(i), branch_taken, m_stalling(i) || branch_taken};
        n_checks++; if ({act_ctrl, act_rd, act_valid} !== {m_exp_ctrl(i), m_exp_rd(i), m_exp_valid(i)})
          $display("FAIL rand_stages dut%0d cyc%0d: got %h/%h/%b want %h/%h/%b", i, n,
                   act_ctrl, act_rd, act_valid, m_exp_ctrl(i), m_exp_rd(i), m_exp_valid(i)); else n_pass++;
        n_checks++; if (act_ctl !== exp_ctl)
          $display("FAIL rand_control dut%0d cyc%0d: got pc/ifid/flush/bubble=%b want %b", i, n, act_ctl, exp_ctl); else n_pass++;
        n_checks++; if (act_sc !== 16'(m_stall[i]) || act_fc !== 16'(m_flush[i]))
          $display("FAIL rand_counters dut%0d cyc%0d: got stall=%0d flush=%0d want %0d/%0d", i, n,
                   act_sc, act_fc, m_stall[i], m_flush[i]); else n_pass++;
      end
      tick();
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    apply_reset();
    test_reset();
    test_latency();
    test_load_use();
    test_long_stall();
    test_flush_in_stall();
    test_same_cycle();
    test_flush_saturate();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
